// File: rtl/fetch_npc_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_npc_unit_pkg : next-PC op encodings and shared fetch constants       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_npc_unit_pkg;

  typedef enum logic [2:0] {
    NPCOP_PC4    = 3'd0,
    NPCOP_BRANCH = 3'd1,
    NPCOP_J      = 3'd2,
    NPCOP_JR     = 3'd3
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  // Branch offsets are word offsets; scale to bytes after sign extension.
  function automatic logic [31:0] sext16_x4(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_npc_unit_npc_calc.sv
// +----------------------------------------------------------------------------+
// | fetch_npc_unit_npc_calc : combinational next-PC selector                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_npc_unit_npc_calc
  import fetch_npc_unit_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [2:0]  npc_op_d,
  input  logic        cmp_result_d,
  input  logic [15:0] imm16_d,
  input  logic [25:0] index26_d,
  input  logic [31:0] jr_target_d,
  output logic [31:0] npc
);

  logic [31:0] w_pc_f4;
  logic [31:0] w_pc_d4;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  npc_op_e     w_op;

  assign w_pc_f4         = pc_f + 32'd4;
  assign w_pc_d4         = pc_d + 32'd4;
  assign w_branch_target = w_pc_d4 + sext16_x4(imm16_d);
  // Jump region comes from the delay-slot address, not the branch itself.
  assign w_jump_target   = {w_pc_d4[31:28], index26_d, 2'b00};
  assign w_op            = npc_op_e'(npc_op_d);

  always_comb begin
    npc = w_pc_f4;
    case (w_op)
      NPCOP_BRANCH: npc = cmp_result_d ? w_branch_target : w_pc_f4;
      NPCOP_J:      npc = w_jump_target;
      NPCOP_JR:     npc = jr_target_d;
      default:      npc = w_pc_f4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_npc_unit.sv
// +----------------------------------------------------------------------------+
// | fetch_npc_unit : IF PC register, next-PC select and IF/ID register         |
// | Optional fetch address-error detection under macro FETCH_ADEL_EN           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_npc_unit
  import fetch_npc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_f,
  input  logic [2:0]  npc_op_d,
  input  logic        cmp_result_d,
  input  logic [15:0] imm16_d,
  input  logic [25:0] index26_d,
  input  logic [31:0] jr_target_d,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc8_d,
  output logic        exc_adel_d
);

  logic [31:0] r_pc_f;
  logic [31:0] r_pc_d;
  logic [31:0] r_instr_d;
  logic [31:0] w_npc;

  fetch_npc_unit_npc_calc u_npc_calc (
    .pc_f         (r_pc_f),
    .pc_d         (r_pc_d),
    .npc_op_d     (npc_op_d),
    .cmp_result_d (cmp_result_d),
    .imm16_d      (imm16_d),
    .index26_d    (index26_d),
    .jr_target_d  (jr_target_d),
    .npc          (w_npc)
  );

  // Delay-slot semantics: no flush, so IF/ID always captures the fetched word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f <= RESET_PC;
    end else if (!stall) begin
      r_pc_f <= w_npc;
    end
  end

`ifdef FETCH_ADEL_EN
  localparam logic [32:0] c_IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic w_fault;
  logic r_adel_d;

  assign w_fault = (r_pc_f[1:0] != 2'b00)
                || (r_pc_f < IM_BASE)
                || ({1'b0, r_pc_f} >= c_IM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_d    <= 32'd0;
      r_instr_d <= NOP;
      r_adel_d  <= 1'b0;
    end else if (!stall) begin
      r_pc_d    <= r_pc_f;
      r_instr_d <= w_fault ? NOP : instr_f;
      r_adel_d  <= w_fault;
    end
  end

  assign exc_adel_d = r_adel_d;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_d    <= 32'd0;
      r_instr_d <= NOP;
    end else if (!stall) begin
      r_pc_d    <= r_pc_f;
      r_instr_d <= instr_f;
    end
  end

  assign exc_adel_d = 1'b0;
`endif

  assign pc_f    = r_pc_f;
  assign pc_d    = r_pc_d;
  assign instr_d = r_instr_d;
  assign pc8_d   = r_pc_d + 32'd8;

endmodule

`default_nettype wire

// File: doc/fetch_npc_unit.md
Name: fetch_npc_unit

Overview:
- IF-stage PC register, next-PC selector and IF/ID pipeline register in one block.
- Consumes the ID-stage branch compare result and decoded jump/branch fields, and redirects fetch.
- MIPS branch-delay-slot semantics: the instruction after a branch always executes, so there is no flush path.
- Sits between instruction memory and the ID stage. It feeds the ID-stage comparator's instruction through instr_d.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into pc_f on reset.
- IM_BASE, 32'h0000_3000, first byte address of instruction memory.
- IM_WORDS, 4096, instruction memory depth in 32-bit words.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears PC and IF/ID register
- stall  in  1  from hazard unit; freezes pc_f and the IF/ID register
- instr_f  in  32  IM read data for the current pc_f (combinational IM)
- npc_op_d  in  3  ID-stage next-PC operation: NPCOP_PC4, NPCOP_BRANCH, NPCOP_J, NPCOP_JR
- cmp_result_d  in  1  ID-stage branch condition result
- imm16_d  in  16  branch offset field of the instruction in ID
- index26_d  in  26  jump index field of the instruction in ID
- jr_target_d  in  32  forwarded rs value for jr/jalr
- pc_f  out  32  current fetch address to IM
- pc_d  out  32  PC of the instruction held in ID
- instr_d  out  32  instruction held in ID
- pc8_d  out  32  pc_d + 8, link address for jal/jalr
- exc_adel_d  out  1  fetch address error flag for the ID instruction

Behaviour:
- The clock is clk. Reset is synchronous and active-high on reset. Reset has priority over stall.
- Reset values: pc_f = RESET_PC, pc_d = 0, instr_d = 0 (nop), exc_adel_d = 0. pc8_d is combinational from pc_d, so it reads 8 after reset.
- Targets are computed from ID-stage state:
  - branch target = pc_d + 4 + (sign-extend(imm16_d) << 2)
  - jump target = {pc_d[31:28] + carry-adjusted pc_d+4 upper bits, index26_d, 2'b00}, i.e. (pc_d+4)[31:28] concatenated with index26_d and 2'b00
  - jr target = jr_target_d, used unmodified
- Next PC selection:
  - NPCOP_BRANCH with cmp_result_d=1 selects the branch target.
  - NPCOP_BRANCH with cmp_result_d=0 selects pc_f + 4.
  - NPCOP_J selects the jump target; NPCOP_JR selects the jr target.
  - NPCOP_PC4 and any undefined encoding select pc_f + 4.
- Delay slot: while a branch is in ID, its delay slot is being fetched at pc_f. The redirect therefore takes effect for the fetch after the delay slot, with no squash.
- Per rising edge with stall=0: pc_f <= next PC; pc_d <= pc_f; instr_d <= instr_f.
- Per rising edge with stall=1: pc_f, pc_d, instr_d and exc_adel_d hold. The branch stays in ID, and its redirect is recomputed once stall drops, so a redirect is never lost or applied twice.
- All adds are modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0. Negative offsets use two's complement.
- Latency: a redirect decided in ID in cycle N appears on pc_f in cycle N+1.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- Defined:
  - pc_f is faulting if pc_f[1:0] != 0, or if pc_f lies outside [IM_BASE, IM_BASE + 4*IM_WORDS).
  - On a non-stalled edge with a faulting pc_f: exc_adel_d <= 1, instr_d <= 0 (nop), pc_d <= the faulting pc_f.
  - Otherwise exc_adel_d <= 0. pc_f still advances normally.
- Undefined: exc_adel_d is tied to 0, no range or alignment logic is built, and instr_d always captures instr_f.

Decomposition:
- Shared macro/constants file holds:
  - NPCOP_PC4/BRANCH/J/JR encodings (3 bits)
  - RESET_PC default
  - NOP encoding 32'h0
- One natural combinational sub-module, npc_calc: takes pc_f, pc_d, npc_op_d, cmp_result_d, imm16_d, index26_d and jr_target_d, and outputs the next PC.
- The top level holds only the PC and IF/ID registers plus the optional ADEL check.

Test Plan:
- Reset then 3 free-running cycles, stall=0, npc_op_d=PC4 -> pc_f sequence 0x3000, 0x3004, 0x3008, 0x300C. instr_d = 0 in cycle 1, then follows instr_f.
- Branch at pc_d=0x3010, imm16=0xFFFC, cmp_result_d=1 -> delay slot 0x3014 is fetched, then pc_f = 0x3004. With cmp_result_d=0 -> pc_f = 0x3018.
- stall=1 for 2 cycles while a branch (target 0x3040) is in ID -> pc_f, pc_d and instr_d hold. First edge after stall=0 gives pc_f = 0x3040, exactly once.
- J with pc_d=0x3020, index26=0x0000C10 -> pc_f = 0x0000_3040. JR with jr_target_d=0x0000_3100 -> pc_f = 0x3100. pc8_d = 0x3028 while pc_d = 0x3020.
- Reset asserted together with stall=1 mid-branch -> pc_f = 0x3000, instr_d = 0, pc_d = 0 on the next edge.
- FETCH_ADEL_EN defined, JR to 0x3002 -> next edge exc_adel_d=1, instr_d=0, pc_d=0x3002. JR to 0x7000 (out of range) -> same flag. Macro undefined -> flag stays 0.
